// File: rtl/vga_pkg.sv
// Shared video types, standard timing sets and the colour-bar table.
// Latency: none (declarations only).
// Backpressure: none.
package vga_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // 1280x1024 @ 60 Hz
  localparam int SXGA_H_DISP   = 1280;
  localparam int SXGA_H_FPORCH = 48;
  localparam int SXGA_H_SYNC   = 112;
  localparam int SXGA_H_BPORCH = 248;
  localparam int SXGA_V_DISP   = 1024;
  localparam int SXGA_V_FPORCH = 1;
  localparam int SXGA_V_SYNC   = 3;
  localparam int SXGA_V_BPORCH = 38;

  // 640x480 @ 60 Hz
  localparam int VGA_H_DISP    = 640;
  localparam int VGA_H_FPORCH  = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BPORCH  = 48;
  localparam int VGA_V_DISP    = 480;
  localparam int VGA_V_FPORCH  = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BPORCH  = 33;

  // Colour bars, left to right
  localparam rgb_t BAR_COLORS [0:7] = '{
    24'hFFFFFF, // white
    24'hFFFF00, // yellow
    24'h00FFFF, // cyan
    24'h00FF00, // green
    24'hFF00FF, // magenta
    24'hFF0000, // red
    24'h0000FF, // blue
    24'h000000  // black
  };

  function automatic rgb_t bar_color(input logic [2:0] idx);
    return BAR_COLORS[idx];
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Raster counters producing registered coordinates, DE, sync, frame strobe and frame count.
// Latency: every output is one register stage behind the h/v counters.
// Backpressure: none; free-running on the pixel clock.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_DISP    = SXGA_H_DISP,
  parameter int H_FPORCH  = SXGA_H_FPORCH,
  parameter int H_SYNC    = SXGA_H_SYNC,
  parameter int H_BPORCH  = SXGA_H_BPORCH,
  parameter int V_DISP    = SXGA_V_DISP,
  parameter int V_FPORCH  = SXGA_V_FPORCH,
  parameter int V_SYNC    = SXGA_V_SYNC,
  parameter int V_BPORCH  = SXGA_V_BPORCH,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int PIX_WIDTH = 12
) (
  input  logic                 clk_vga,
  input  logic                 rst,
  output logic [PIX_WIDTH-1:0] pix_x,
  output logic [PIX_WIDTH-1:0] pix_y,
  output logic                 pix_de,
  output logic                 hs,
  output logic                 vs,
  output logic                 frame_start,
  output logic [15:0]          frame_cnt
);

  localparam int H_TOTAL = H_DISP + H_FPORCH + H_SYNC + H_BPORCH;
  localparam int V_TOTAL = V_DISP + V_FPORCH + V_SYNC + V_BPORCH;
  localparam int CW      = 16;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_DISP);
  localparam logic [CW-1:0] V_ACT    = CW'(V_DISP);
  localparam logic [CW-1:0] H_SYNC_S = CW'(H_DISP + H_FPORCH);
  localparam logic [CW-1:0] H_SYNC_E = CW'(H_DISP + H_FPORCH + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_S = CW'(V_DISP + V_FPORCH);
  localparam logic [CW-1:0] V_SYNC_E = CW'(V_DISP + V_FPORCH + V_SYNC);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          active;
  logic          hs_act;
  logic          vs_act;
  logic          frame_wrap;

  assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_act     = (h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E);
  assign vs_act     = (v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E);
  assign frame_wrap = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // Raster position: h wraps every line, v advances on each h wrap
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Register coordinate-side outputs from the counters; coordinates read 0 outside the active area
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      pix_x       <= '0;
      pix_y       <= '0;
      pix_de      <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      pix_x       <= active ? PIX_WIDTH'(h_cnt) : '0;
      pix_y       <= active ? PIX_WIDTH'(v_cnt) : '0;
      pix_de      <= active;
      hs          <= hs_act ? HS_POL : ~HS_POL;
      vs          <= vs_act ? VS_POL : ~VS_POL;
      frame_start <= active && (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // Count a frame only when the raster completes it; a reset drops any partial frame
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (frame_wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/vga_layer_compositor.sv
// VGA output stage: raster timing, fixed-priority layer merge (lowest index wins), aligned sync/DE/RGB.
// Latency: coordinates to RGB/sync/DE is LAYER_LATENCY+1 cycles; optional colour bars via COMPOSITOR_TEST_PATTERN_EN.
// Backpressure: none; layers must answer exactly LAYER_LATENCY cycles after each coordinate.
module vga_layer_compositor
  import vga_pkg::*;
#(
  parameter int          H_DISP        = SXGA_H_DISP,
  parameter int          H_FPORCH      = SXGA_H_FPORCH,
  parameter int          H_SYNC        = SXGA_H_SYNC,
  parameter int          H_BPORCH      = SXGA_H_BPORCH,
  parameter int          V_DISP        = SXGA_V_DISP,
  parameter int          V_FPORCH      = SXGA_V_FPORCH,
  parameter int          V_SYNC        = SXGA_V_SYNC,
  parameter int          V_BPORCH      = SXGA_V_BPORCH,
  parameter bit          HS_POL        = 1'b0,
  parameter bit          VS_POL        = 1'b0,
  parameter int          PIX_WIDTH     = 12,
  parameter int          LAYER_CNT     = 2,
  parameter int          LAYER_LATENCY = 1,
  parameter logic [23:0] BG_COLOR      = 24'h000000
) (
  input  logic                    clk_vga,
  input  logic                    rst,
  input  logic [LAYER_CNT*24-1:0] layer_data_i,
  input  logic [LAYER_CNT-1:0]    layer_en_i,
  input  logic [LAYER_CNT-1:0]    layer_mask_i,
`ifdef COMPOSITOR_TEST_PATTERN_EN
  input  logic                    test_pattern_i,
`endif
  output logic [PIX_WIDTH-1:0]    pix_x_o,
  output logic [PIX_WIDTH-1:0]    pix_y_o,
  output logic                    pix_de_o,
  output logic                    frame_start_o,
  output logic [15:0]             frame_cnt_o,
  output logic                    vga_hs_o,
  output logic                    vga_vs_o,
  output logic                    vga_de_o,
  output logic [7:0]              vga_r_o,
  output logic [7:0]              vga_g_o,
  output logic [7:0]              vga_b_o
);

  localparam int         DL        = LAYER_LATENCY + 1;
  localparam logic [2:0] SYNC_IDLE = {~HS_POL, ~VS_POL, 1'b0};

  logic       tc_hs;
  logic       tc_vs;
  logic [2:0] sync_in;            // {hs, vs, de} as issued with the coordinates
  logic [2:0] sync_q [1:DL];
  logic       blank_de;           // DE belonging to the layer data presented this cycle
  rgb_t       merged;
  rgb_t       pixel_sel;
  rgb_t       rgb_q;

  vga_timing_counter #(
    .H_DISP    (H_DISP),
    .H_FPORCH  (H_FPORCH),
    .H_SYNC    (H_SYNC),
    .H_BPORCH  (H_BPORCH),
    .V_DISP    (V_DISP),
    .V_FPORCH  (V_FPORCH),
    .V_SYNC    (V_SYNC),
    .V_BPORCH  (V_BPORCH),
    .HS_POL    (HS_POL),
    .VS_POL    (VS_POL),
    .PIX_WIDTH (PIX_WIDTH)
  ) u_timing (
    .clk_vga     (clk_vga),
    .rst         (rst),
    .pix_x       (pix_x_o),
    .pix_y       (pix_y_o),
    .pix_de      (pix_de_o),
    .hs          (tc_hs),
    .vs          (tc_vs),
    .frame_start (frame_start_o),
    .frame_cnt   (frame_cnt_o)
  );

  assign sync_in = {tc_hs, tc_vs, pix_de_o};

  // Sync/DE shift line; reset fills every stage with inactive levels
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      for (int i = 1; i <= DL; i++) sync_q[i] <= SYNC_IDLE;
    end else begin
      sync_q[1] <= sync_in;
      for (int i = 2; i <= DL; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Tap one stage short of the output: the merge register adds the final stage
  generate
    if (LAYER_LATENCY == 0) begin : g_tap_direct
      assign blank_de = sync_in[0];
    end else begin : g_tap_line
      assign blank_de = sync_q[LAYER_LATENCY][0];
    end
  endgenerate

  // Fixed-priority merge: scan downwards so the lowest qualifying layer overwrites last
  always_comb begin
    merged = BG_COLOR;
    for (int k = LAYER_CNT - 1; k >= 0; k--) begin
      if (layer_en_i[k] && layer_mask_i[k]) merged = layer_data_i[24*k +: 24];
    end
  end

`ifdef COMPOSITOR_TEST_PATTERN_EN
  localparam int BAR_W = (H_DISP / 8 > 0) ? H_DISP / 8 : 1;

  logic [PIX_WIDTH-1:0] bar_full;
  logic [2:0]           bar_now;
  logic [2:0]           bar_aligned;

  assign bar_full = pix_x_o / PIX_WIDTH'(BAR_W);
  assign bar_now  = (bar_full > PIX_WIDTH'(7)) ? 3'd7 : bar_full[2:0];

  // Delay the bar index so it lines up with layer data of the same pixel
  generate
    if (LAYER_LATENCY == 0) begin : g_bar_direct
      assign bar_aligned = bar_now;
    end else begin : g_bar_line
      logic [2:0] bar_q [1:LAYER_LATENCY];
      // Bar index shift line, same depth as the layer round trip
      always_ff @(posedge clk_vga) begin
        if (rst) begin
          for (int i = 1; i <= LAYER_LATENCY; i++) bar_q[i] <= 3'd0;
        end else begin
          bar_q[1] <= bar_now;
          for (int i = 2; i <= LAYER_LATENCY; i++) bar_q[i] <= bar_q[i-1];
        end
      end
      assign bar_aligned = bar_q[LAYER_LATENCY];
    end
  endgenerate

  // Colour bars replace the layer merge while the pattern is selected
  always_comb begin
    pixel_sel = merged;
    if (test_pattern_i) pixel_sel = bar_color(bar_aligned);
  end
`else
  // Without the pattern option the merge result goes straight to the output register
  always_comb begin
    pixel_sel = merged;
  end
`endif

  // Output colour register, forced to black whenever the aligned DE is low
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      rgb_q <= '0;
    end else if (!blank_de) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= pixel_sel;
    end
  end

  assign vga_hs_o = sync_q[DL][2];
  assign vga_vs_o = sync_q[DL][1];
  assign vga_de_o = sync_q[DL][0];
  assign vga_r_o  = rgb_q.r;
  assign vga_g_o  = rgb_q.g;
  assign vga_b_o  = rgb_q.b;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Bench for vga_layer_compositor on a tiny 16x8 raster with two layers and latency 2.
// Latency: reference model predicts every output on every cycle from the raster index.
// Backpressure: n/a.
module tb_vga_layer_compositor;

  localparam int          HT  = 16;
  localparam int          VT  = 8;
  localparam int          FT  = HT * VT;
  localparam int          LAT = 2;
  localparam logic [23:0] BG  = 24'h123456;

  logic        clk_vga = 1'b0;
  logic        rst;
  logic [47:0] layer_data;
  logic [1:0]  layer_en;
  logic [1:0]  layer_mask;
`ifdef COMPOSITOR_TEST_PATTERN_EN
  logic        test_pattern;
`endif
  logic [11:0] pix_x_o, pix_y_o;
  logic        pix_de_o, frame_start_o;
  logic [15:0] frame_cnt_o;
  logic        vga_hs_o, vga_vs_o, vga_de_o;
  logic [7:0]  vga_r_o, vga_g_o, vga_b_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   c        = 0;
  logic lat_mode = 1'b0;
  logic [7:0] xh0 = 8'd0, xh1 = 8'd0, xh2 = 8'd0;

  always #5 clk_vga = ~clk_vga;

  vga_layer_compositor #(
    .H_DISP (8), .H_FPORCH (2), .H_SYNC (3), .H_BPORCH (3),
    .V_DISP (4), .V_FPORCH (1), .V_SYNC (2), .V_BPORCH (1),
    .HS_POL (1'b0), .VS_POL (1'b0), .PIX_WIDTH (12),
    .LAYER_CNT (2), .LAYER_LATENCY (LAT), .BG_COLOR (BG)
  ) dut (
    .clk_vga       (clk_vga),
    .rst           (rst),
    .layer_data_i  (layer_data),
    .layer_en_i    (layer_en),
    .layer_mask_i  (layer_mask),
`ifdef COMPOSITOR_TEST_PATTERN_EN
    .test_pattern_i(test_pattern),
`endif
    .pix_x_o       (pix_x_o),
    .pix_y_o       (pix_y_o),
    .pix_de_o      (pix_de_o),
    .frame_start_o (frame_start_o),
    .frame_cnt_o   (frame_cnt_o),
    .vga_hs_o      (vga_hs_o),
    .vga_vs_o      (vga_vs_o),
    .vga_de_o      (vga_de_o),
    .vga_r_o       (vga_r_o),
    .vga_g_o       (vga_g_o),
    .vga_b_o       (vga_b_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  // First enabled, unmasked layer in index order supplies the pixel
  function automatic logic [23:0] ref_merge(input logic [47:0] d, input logic [1:0] en,
                                            input logic [1:0] m);
    for (int k = 0; k < 2; k++)
      if (en[k] && m[k]) return d[24*k +: 24];
    return BG;
  endfunction

  function automatic logic [23:0] ref_bar(input int idx);
    logic [23:0] bars [0:7];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return bars[idx];
  endfunction

  // One clock: c counts cycles since reset release; coordinates describe raster index c-1,
  // VGA outputs describe raster index c-(LAT+2)
  task automatic tick();
    logic        was_rst, tp, de_e, hs_e, vs_e, act;
    logic [23:0] pend, rgb_e;
    int          pv, po, h, v;
    was_rst = rst;
    pend    = ref_merge(layer_data, layer_en, layer_mask);
    tp      = 1'b0;
`ifdef COMPOSITOR_TEST_PATTERN_EN
    tp      = test_pattern;
`endif
    @(posedge clk_vga);
    #1;
    c  = was_rst ? 0 : c + 1;
    pv = c - 1;
    po = c - (LAT + 2);

    if (pv >= 0) begin
      h = pv % HT;  v = (pv / HT) % VT;
      act = (h < 8) && (v < 4);
      chk("pix_x", pix_x_o, act ? h : 0);
      chk("pix_y", pix_y_o, act ? v : 0);
      chk("pix_de", pix_de_o, act);
      chk("frame_start", frame_start_o, (pv % FT) == 0);
    end else begin
      chk("pix_x_rst", pix_x_o, 0);
      chk("pix_y_rst", pix_y_o, 0);
      chk("pix_de_rst", pix_de_o, 0);
      chk("frame_start_rst", frame_start_o, 0);
    end
    chk("frame_cnt", frame_cnt_o, (c / FT) % 65536);

    if (po >= 0) begin
      h = po % HT;  v = (po / HT) % VT;
      de_e = (h < 8) && (v < 4);
      hs_e = !((h >= 10) && (h < 13));
      vs_e = !((v >= 5) && (v < 7));
    end else begin
      h = 0;  de_e = 1'b0;  hs_e = 1'b1;  vs_e = 1'b1;
    end
    if (tp) pend = ref_bar(h);
    rgb_e = de_e ? pend : 24'h0;
    chk("vga_de", vga_de_o, de_e);
    chk("vga_hs", vga_hs_o, hs_e);
    chk("vga_vs", vga_vs_o, vs_e);
    chk("vga_rgb", {vga_r_o, vga_g_o, vga_b_o}, rgb_e);
    if (lat_mode && de_e) chk("lat_r", vga_r_o, h);
  endtask

  initial begin
    rst        = 1'b1;
    layer_data = 48'h0;
    layer_en   = 2'b00;
    layer_mask = 2'b11;
`ifdef COMPOSITOR_TEST_PATTERN_EN
    test_pattern = 1'b0;
`endif
    repeat (3) tick();

    // Random layer traffic across more than one frame
    rst = 1'b0;
    repeat (140) begin
      layer_data = {16'($urandom), 32'($urandom)};
      layer_en   = 2'($urandom);
      layer_mask = 2'($urandom);
      tick();
    end

    // Priority, masking and background
    layer_data = {24'h00FF00, 24'hFF0000};
    layer_en   = 2'b11;
    layer_mask = 2'b11;
    repeat (20) tick();
    layer_mask = 2'b10;
    repeat (20) tick();
    layer_en   = 2'b00;
    repeat (20) tick();

    // Layer 1 echoes pix_x from LAT cycles earlier
    layer_en   = 2'b10;
    layer_mask = 2'b11;
    for (int i = 0; i < 150; i++) begin
      lat_mode = (i >= 4);
      tick();
      xh2 = xh1;  xh1 = xh0;  xh0 = pix_x_o[7:0];
      layer_data = {xh2, 16'h0000, 24'hABCDEF};
    end
    lat_mode = 1'b0;

    // Saturated layers must still blank outside the active area
    layer_data = {24'hFFFFFF, 24'hFFFFFF};
    layer_en   = 2'b11;
    repeat (40) tick();

    // Reset in the middle of line 2, at h = 5
    for (int i = 0; i < 2 * FT && (c % FT) != 2 * HT + 5; i++) tick();
    chk("reset_point", c % FT, 2 * HT + 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (30) tick();

`ifdef COMPOSITOR_TEST_PATTERN_EN
    test_pattern = 1'b1;
    repeat (2 * HT + 8) tick();
    test_pattern = 1'b0;
    repeat (8) tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
